// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect4 turn arbiter and its neighbours.
package connect4_pkg;

  typedef enum logic [2:0] {IDLE, WAIT_MOVE, LOAD, SETTLE, SWAP} arb_state_t;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_FPGA  = 2'b01;
  localparam logic [1:0] CELL_ARD   = 2'b10;

  localparam logic PLAYER_FPGA = 1'b0;
  localparam logic PLAYER_ARD  = 1'b1;

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: counts CLK_HZ cycles per second while run is high, flags expiry
// once TURN_SECS whole seconds have elapsed.
module turn_timer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TURN_SECS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       run,
  output logic [3:0] secs_left,
  output logic       expired
);
  localparam int CYC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CYC_W-1:0] cyc;
  logic [3:0]       secs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc  <= '0;
      secs <= '0;
    end else if (clear) begin
      cyc  <= '0;
      secs <= '0;
    end else if (run && !expired) begin
      if (cyc == CYC_W'(CLK_HZ - 1)) begin
        cyc  <= '0;
        secs <= secs + 4'd1;
      end else begin
        cyc <= cyc + 1'b1;
      end
    end
  end

  // Seconds stop advancing at expiry, so the remaining count saturates at zero.
  assign expired   = (secs >= 4'(TURN_SECS));
  assign secs_left = expired ? 4'd0 : 4'(TURN_SECS) - secs;

endmodule

// File: rtl/turn_arbiter.sv
// Connect4 turn arbiter: grants the player on turn, times the turn and drives the loader.
// Build option AUTO_MOVE_EN: an expired turn drops a piece in the lowest free column.
module turn_arbiter
  import connect4_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int TURN_SECS     = 10,
  parameter int COLS          = 7,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            first_player,
  input  logic            game_over,
  input  logic            fpga_req,
  input  logic [2:0]      fpga_col,
  input  logic            ard_req,
  input  logic [2:0]      ard_col,
  input  logic [COLS-1:0] col_full,
  output logic            load_en,
  output logic [2:0]      load_col,
  output logic [1:0]      load_val,
  output logic            fpga_ack,
  output logic            ard_ack,
  output logic            reject,
  output logic            timeout,
  output logic            turn_player,
  output logic [3:0]      secs_left
);
  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  arb_state_t      state, state_nx;
  logic [SC_W-1:0] settle_cnt;
  logic            fpga_blk, ard_blk;
  logic            expired, timer_clear, timer_run;
  logic            cur_req, cur_blk, cur_legal, move_ok, bad_req, settle_done;
  logic [2:0]      cur_col;
  logic            fpga_ack_nx, ard_ack_nx, reject_nx, timeout_nx, load_en_nx, load_set;
  logic [2:0]      load_col_nx;
  logic            auto_hit;
  logic [2:0]      auto_col;

  function automatic logic col_ok(input logic [2:0] col, input logic [COLS-1:0] full);
    col_ok = 1'b0;
    for (int c = 0; c < COLS; c++)
      if (col == 3'(c)) col_ok = !full[c];
  endfunction

  turn_timer #(.CLK_HZ(CLK_HZ), .TURN_SECS(TURN_SECS)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (timer_clear),
    .run       (timer_run),
    .secs_left (secs_left),
    .expired   (expired)
  );

`ifdef AUTO_MOVE_EN
  always_comb begin
    auto_hit = 1'b0;
    auto_col = '0;
    for (int c = COLS - 1; c >= 0; c--)
      if (!col_full[c]) begin
        auto_hit = 1'b1;
        auto_col = 3'(c);
      end
  end
`else
  assign auto_hit = 1'b0;
  assign auto_col = '0;
`endif

  // Only the player on turn is looked at; a held illegal request rejects once.
  assign cur_req     = (turn_player == PLAYER_ARD) ? ard_req : fpga_req;
  assign cur_col     = (turn_player == PLAYER_ARD) ? ard_col : fpga_col;
  assign cur_blk     = (turn_player == PLAYER_ARD) ? ard_blk : fpga_blk;
  assign cur_legal   = col_ok(cur_col, col_full);
  assign move_ok     = (state == WAIT_MOVE) && cur_req && cur_legal;
  assign bad_req     = (state == WAIT_MOVE) && cur_req && !cur_legal && !cur_blk;
  assign settle_done = (settle_cnt == SC_W'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (game_over) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:      if (start) state_nx = WAIT_MOVE;
        WAIT_MOVE: if (move_ok) state_nx = LOAD;
                   else if (expired) state_nx = auto_hit ? SETTLE : SWAP;
        LOAD:      state_nx = SETTLE;
        SETTLE:    if (settle_done) state_nx = SWAP;
        SWAP:      state_nx = WAIT_MOVE;
        default:   state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    fpga_ack_nx = 1'b0;
    ard_ack_nx  = 1'b0;
    reject_nx   = 1'b0;
    timeout_nx  = 1'b0;
    load_en_nx  = 1'b0;
    load_set    = 1'b0;
    load_col_nx = cur_col;
    timer_run   = (state == WAIT_MOVE);
    timer_clear = (state == SWAP) || ((state == IDLE) && start);
    if (!game_over) begin
      if (move_ok) begin
        fpga_ack_nx = (turn_player == PLAYER_FPGA);
        ard_ack_nx  = (turn_player == PLAYER_ARD);
        load_set    = 1'b1;
      end else if ((state == WAIT_MOVE) && expired) begin
        timeout_nx = 1'b1;
        if (auto_hit) begin
          load_en_nx  = 1'b1;
          load_set    = 1'b1;
          load_col_nx = auto_col;
        end
      end
      if (bad_req) reject_nx = 1'b1;
      if (state == LOAD) load_en_nx = 1'b1;
    end
  end

  // Registered strobes: request seen in N gives ack in N+1 and load_en in N+2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpga_ack    <= 1'b0;
      ard_ack     <= 1'b0;
      reject      <= 1'b0;
      timeout     <= 1'b0;
      load_en     <= 1'b0;
      load_col    <= '0;
      load_val    <= CELL_EMPTY;
      turn_player <= PLAYER_FPGA;
      settle_cnt  <= '0;
      fpga_blk    <= 1'b0;
      ard_blk     <= 1'b0;
    end else begin
      fpga_ack <= fpga_ack_nx;
      ard_ack  <= ard_ack_nx;
      reject   <= reject_nx;
      timeout  <= timeout_nx;
      load_en  <= load_en_nx;
      if (load_set) begin
        load_col <= load_col_nx;
        load_val <= (turn_player == PLAYER_ARD) ? CELL_ARD : CELL_FPGA;
      end
      if ((state == IDLE) && start && !game_over) turn_player <= first_player;
      else if ((state == SWAP) && !game_over)     turn_player <= ~turn_player;
      settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
      fpga_blk   <= fpga_req && (fpga_blk || (reject_nx && (turn_player == PLAYER_FPGA)));
      ard_blk    <= ard_req && (ard_blk || (reject_nx && (turn_player == PLAYER_ARD)));
    end
  end

endmodule

// File: tb/tb_turn_arbiter.sv
// Directed bench for turn_arbiter (CLK_HZ=10, TURN_SECS=3); stimulus queues expected strobes,
// a negedge monitor pops and compares them. Define AUTO_MOVE_EN to match an auto-move build.
module tb_turn_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, first_player = 1'b0, game_over = 1'b0;
  logic       fpga_req = 1'b0, ard_req = 1'b0;
  logic [2:0] fpga_col = '0, ard_col = '0;
  logic [6:0] col_full = '0;
  logic       load_en, fpga_ack, ard_ack, reject, timeout, turn_player;
  logic [2:0] load_col;
  logic [1:0] load_val;
  logic [3:0] secs_left;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0] strb;
    logic [2:0] col;
    logic [1:0] val;
  } ev_t;
  ev_t exp_q[$];

  localparam logic [4:0] S_LOAD = 5'b10000;
  localparam logic [4:0] S_FACK = 5'b01000;
  localparam logic [4:0] S_AACK = 5'b00100;
  localparam logic [4:0] S_REJ  = 5'b00010;
  localparam logic [4:0] S_TO   = 5'b00001;

  always #5 clk = ~clk;

  turn_arbiter #(.CLK_HZ(10), .TURN_SECS(3), .COLS(7), .SETTLE_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .first_player (first_player),
    .game_over    (game_over),
    .fpga_req     (fpga_req),
    .fpga_col     (fpga_col),
    .ard_req      (ard_req),
    .ard_col      (ard_col),
    .col_full     (col_full),
    .load_en      (load_en),
    .load_col     (load_col),
    .load_val     (load_val),
    .fpga_ack     (fpga_ack),
    .ard_ack      (ard_ack),
    .reject       (reject),
    .timeout      (timeout),
    .turn_player  (turn_player),
    .secs_left    (secs_left)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic ev_t ev(input logic [4:0] s, input logic [2:0] c, input logic [1:0] v);
    ev_t e;
    e.strb = s;
    e.col  = c;
    e.val  = v;
    return e;
  endfunction

  // Legal move by player pl: ack next cycle, load the cycle after, turn swaps after settle.
  task automatic legal_move(input logic pl, input logic [2:0] col, input logic [1:0] val,
                            input string tag);
    exp_q.push_back(ev(pl ? S_AACK : S_FACK, 3'd0, 2'd0));
    exp_q.push_back(ev(S_LOAD, col, val));
    if (pl) begin ard_col = col; ard_req = 1'b1; end
    else    begin fpga_col = col; fpga_req = 1'b1; end
    tick(1);
    chk({tag, "_ack"}, pl ? ard_ack : fpga_ack, 1);
    fpga_req = 1'b0;
    ard_req  = 1'b0;
    tick(1);
    chk({tag, "_load_en"}, load_en, 1);
    chk({tag, "_load_col"}, load_col, col);
    tick(3);
    chk({tag, "_turn"}, turn_player, !pl);
  endtask

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if ({load_en, fpga_ack, ard_ack, reject, timeout} != 5'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe actual=%b required=none",
                   {load_en, fpga_ack, ard_ack, reject, timeout});
        end else begin
          e = exp_q.pop_front();
          chk("mon_strobes", {load_en, fpga_ack, ard_ack, reject, timeout}, e.strb);
          if (e.strb[4]) begin
            chk("mon_load_col", load_col, e.col);
            chk("mon_load_val", load_val, e.val);
          end
        end
      end
    end
  end

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_turn", turn_player, 0);
    chk("rst_secs", secs_left, 3);
    chk("rst_load_col", load_col, 0);
    chk("rst_load_val", load_val, 0);
    chk("rst_strobes", {load_en, fpga_ack, ard_ack, reject, timeout}, 0);
    tick(2);
    rst = 1'b1;
    tick(1);

    start = 1'b1;
    first_player = 1'b0;
    tick(1);
    start = 1'b0;
    chk("start_turn", turn_player, 0);
    chk("start_secs", secs_left, 3);

    // 1: FPGA move in column 3.
    legal_move(1'b0, 3'd3, 2'b01, "t1");

    // 2: Arduino's turn, both request; only Arduino is granted.
    fpga_col = 3'd2;
    fpga_req = 1'b1;
    legal_move(1'b1, 3'd5, 2'b10, "t2");

    // 3: full column, out-of-range column, then a legal one.
    col_full = 7'b0010000;
    exp_q.push_back(ev(S_REJ, 3'd0, 2'd0));
    fpga_col = 3'd4;
    fpga_req = 1'b1;
    tick(1);
    chk("t3_reject_full", reject, 1);
    tick(1);
    chk("t3_reject_held", reject, 0);
    tick(1);
    fpga_req = 1'b0;
    tick(1);
    exp_q.push_back(ev(S_REJ, 3'd0, 2'd0));
    fpga_col = 3'd7;
    fpga_req = 1'b1;
    tick(1);
    chk("t3_reject_range", reject, 1);
    chk("t3_no_load", load_en, 0);
    fpga_req = 1'b0;
    tick(1);
    legal_move(1'b0, 3'd0, 2'b01, "t3");

    // 4/5: Arduino idles until the turn expires.
    col_full = 7'b0000011;
    chk("t4_secs3", secs_left, 3);
    tick(10);
    chk("t4_secs2", secs_left, 2);
    tick(10);
    chk("t4_secs1", secs_left, 1);
    tick(10);
    chk("t4_secs0", secs_left, 0);
`ifdef AUTO_MOVE_EN
    exp_q.push_back(ev(S_TO | S_LOAD, 3'd2, 2'b10));
    tick(1);
    chk("t5_timeout", timeout, 1);
    chk("t5_auto_load", load_en, 1);
    chk("t5_auto_col", load_col, 2);
    tick(3);
`else
    exp_q.push_back(ev(S_TO, 3'd0, 2'd0));
    tick(1);
    chk("t4_timeout", timeout, 1);
    chk("t4_no_load", load_en, 0);
    tick(1);
`endif
    chk("t4_turn", turn_player, 0);
    chk("t4_secs_reload", secs_left, 3);

    // 6: game_over during SETTLE suppresses the swap; game_over beats start.
    exp_q.push_back(ev(S_FACK, 3'd0, 2'd0));
    exp_q.push_back(ev(S_LOAD, 3'd6, 2'b01));
    fpga_col = 3'd6;
    fpga_req = 1'b1;
    tick(1);
    chk("t6_ack", fpga_ack, 1);
    fpga_req = 1'b0;
    tick(1);
    chk("t6_load_en", load_en, 1);
    game_over = 1'b1;
    tick(4);
    chk("t6_no_swap", turn_player, 0);
    start = 1'b1;
    first_player = 1'b1;
    tick(1);
    start = 1'b0;
    game_over = 1'b0;
    chk("t6_start_ignored", turn_player, 0);
    fpga_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t6_idle_no_ack", fpga_ack, 0);
    end
    fpga_req = 1'b0;

    // Restart with Arduino first, then reset while the load is pending.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t6_first_ard", turn_player, 1);
    exp_q.push_back(ev(S_AACK, 3'd0, 2'd0));
    ard_col = 3'd2;
    ard_req = 1'b1;
    tick(1);
    chk("t6_ard_ack", ard_ack, 1);
    ard_req = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_strobes", {load_en, fpga_ack, ard_ack, reject, timeout}, 0);
    chk("t6_rst_turn", turn_player, 0);
    chk("t6_rst_secs", secs_left, 3);
    chk("t6_rst_load_col", load_col, 0);
    chk("t6_rst_load_val", load_val, 0);
    tick(3);
    rst = 1'b1;
    tick(4);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
